adc_spi_responder: RTL and testbench
====================================

Name: adc_spi_responder

Overview:
- SPI peripheral that emulates the team's 2-channel 10-bit ADC, serving as the target end of the ADC read transaction.
- Decodes the command bits START, SGL/DIFF, ODD/SIGN and MSBF from mosi, then shifts a null bit and the selected 10-bit sample onto miso.
- Used as the on-FPGA stand-in for the ADC, and as the bench model for the ADC-read master.
- Runs on the system clock; sck, cs_n and mosi are oversampled.

Parameters:
DATA_BITS, 10, sample width shifted out.
SYNC_STAGES, 2, synchronizer flops on sck, cs_n and mosi.

Ports:
clk  input  1  system clock; must be at least 8x the sck frequency.
reset  input  1  asynchronous, active-low reset.
sck  input  1  SPI clock, mode 0 (idle low), asynchronous to clk.
cs_n  input  1  chip select, active low.
mosi  input  1  command bits from the master.
ch0_sample  input  DATA_BITS  channel 0 value.
ch1_sample  input  DATA_BITS  channel 1 value.
miso  output  1  serial result.
miso_oe  output  1  miso drive enable.
sel_ch  output  1  ODD/SIGN bit of the last decoded command.
sel_sgl  output  1  SGL/DIFF bit of the last decoded command.
conv_start  output  1  one-clk pulse when the sample is latched.
frame_done  output  1  one-clk pulse when the last data bit has been shifted.
frame_abort  output  1  one-clk pulse when cs_n rises before frame_done.

Behaviour:
- Reset values: miso=0, miso_oe=0, sel_ch=0, sel_sgl=0, all pulses 0, state=IDLE.
- Synchronization: sck, cs_n and mosi each pass through SYNC_STAGES flops. sck_rise and sck_fall are detected from the last two synchronized samples.
- Sampling edges: mosi is sampled on sck_rise. miso is updated on sck_fall, exactly SYNC_STAGES+1 clk after the physical sck edge.
- cs_n high, from any state: go to IDLE next clk. miso_oe=0 and miso=0. Pulse frame_abort if the state was not IDLE or DONE. This has priority over every sck event in the same clk.
- IDLE: when cs_n is low, go to WAIT_START. miso_oe=1, miso=0.
- WAIT_START: on sck_rise, mosi=1 goes to SGL; mosi=0 stays in WAIT_START (leading zeros are ignored).
- SGL: on sck_rise, capture sel_sgl=mosi, then go to ODD.
- ODD: on sck_rise, capture sel_ch=mosi, then go to MSBF.
- MSBF: on sck_rise, capture msbf=mosi and latch result; pulse conv_start; go to NULL.
- Result, single-ended (sgl=1): result = sel_ch ? ch1_sample : ch0_sample.
- Result, pseudo-differential (sgl=0): result = (IN+ - IN-) with IN+ = ch0 if odd=0, else ch1. Compute in DATA_BITS+1 bits; a negative result clamps to 0.
- NULL: on sck_fall, drive miso=0, load bit index DATA_BITS-1, go to DATA.
- DATA: on each sck_fall, miso=result[index] and index decrements.
  - After bit 0 is driven, msbf=1 goes to DONE and pulses frame_done.
  - msbf=0 goes to LSBF with index=1.
- LSBF: on each sck_fall, miso=result[index] and index increments.
  - Bit 0 is not repeated.
  - After bit DATA_BITS-1 is driven, go to DONE and pulse frame_done.
- DONE: on sck_fall, miso=0. Stay in DONE until cs_n goes high.
- Sample inputs are read only at the latch instant. Changes afterwards do not affect the frame in progress.
- sck_rise and sck_fall in the same clk cannot occur given the clk/sck ratio. If they do, sck_rise is processed and sck_fall is dropped.
- Asynchronous reset mid-frame returns to IDLE immediately. The master's frame is lost, and no pulse is issued.

Test Plan:
- Single-ended ch0: ch0=0x2A5; master sends 1,1,0,1, then clocks 11 more sck. Required: miso = 0, then 1010100101 MSB first; sel_sgl=1, sel_ch=0; one conv_start and one frame_done pulse.
- Single-ended ch1 with 2 leading zeros: ch1=0x3FF; mosi = 0,0,1,1,1,1. Required: leading zeros ignored, null bit 0, then ten 1s; sel_ch=1.
- LSB-first tail: ch0=0x001; mosi = 1,1,0,0; clock 20 sck. Required: null 0, 0000000001, then 000000000 (bits 1..9 LSB first); frame_done after the 20th sck falling edge.
- Differential clamp: ch0=0x100, ch1=0x180. Command 1,0,0,1 gives result 0x000; command 1,0,1,1 gives result 0x080 on miso.
- Abort: raise cs_n after 6 data bits. Required: frame_abort pulse, miso_oe=0 within SYNC_STAGES+1 clk. The next frame decodes correctly from WAIT_START.
- Reset: assert reset mid-DATA. Required: all outputs at reset values, state IDLE. After release with cs_n low, the block waits for a start bit.

Source files
------------

// File: rtl/adc_spi_responder.sv
// -----------------------------------------------------------------------------
// adc_spi_responder
//
// SPI target that emulates the team's 2-channel 10-bit ADC read transaction.
// The master clocks in START, SGL/DIFF, ODD/SIGN and MSBF on mosi. The block
// then returns a null bit followed by the selected sample on miso, MSB first.
// When MSBF=0, the sample is followed by bits 1..DATA_BITS-1 LSB first.
// All SPI pins are oversampled on clk. clk must run at least 8x sck.
//
// Parameters
//   DATA_BITS    sample width shifted out (>= 2)
//   SYNC_STAGES  synchronizer depth on sck, cs_n and mosi (>= 1)
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   sck          SPI clock, mode 0 (idle low), asynchronous to clk
//   cs_n         chip select, active low
//   mosi         command bits from the master
//   ch0_sample   channel 0 value, read only when the result is latched
//   ch1_sample   channel 1 value, read only when the result is latched
//   miso         serial result
//   miso_oe      miso drive enable (high while selected)
//   sel_ch       ODD/SIGN bit of the last decoded command
//   sel_sgl      SGL/DIFF bit of the last decoded command
//   conv_start   one-clk pulse when the sample is latched
//   frame_done   one-clk pulse when the last data bit has been shifted
//   frame_abort  one-clk pulse when cs_n rises before frame_done
// -----------------------------------------------------------------------------
module adc_spi_responder #(
   parameter int DATA_BITS   = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sck,
   input  logic                 cs_n,
   input  logic                 mosi,
   input  logic [DATA_BITS-1:0] ch0_sample,
   input  logic [DATA_BITS-1:0] ch1_sample,
   output logic                 miso,
   output logic                 miso_oe,
   output logic                 sel_ch,
   output logic                 sel_sgl,
   output logic                 conv_start,
   output logic                 frame_done,
   output logic                 frame_abort
);

   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WAIT_START,
      ST_SGL,
      ST_ODD,
      ST_MSBF,
      ST_NULL,
      ST_DATA,
      ST_LSBF,
      ST_DONE
   } state_t;

   // ---------------------------------------------------------------------------
   // Input synchronizers. Index 0 is the stage closest to the pin.
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sck_prev_q, sck_prev_d;

   logic sck_s, cs_s, mosi_s;
   logic sck_rise, sck_fall;

   always_comb begin
      sck_sync_d[0]  = sck;
      cs_sync_d[0]   = cs_n;
      mosi_sync_d[0] = mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sck_sync_d[i]  = sck_sync_q[i-1];
         cs_sync_d[i]   = cs_sync_q[i-1];
         mosi_sync_d[i] = mosi_sync_q[i-1];
      end
   end

   assign sck_s      = sck_sync_q[SYNC_STAGES-1];
   assign cs_s       = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
   assign sck_prev_d = sck_s;

   // The edge detector compares the last synchronized sample with the one
   // before it. A rise and a fall can therefore never be flagged in the same
   // clk.
   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;

   // ---------------------------------------------------------------------------
   // Frame state and registered outputs
   // ---------------------------------------------------------------------------
   state_t               state_q, state_d;
   logic                 miso_q, miso_d;
   logic                 miso_oe_q, miso_oe_d;
   logic                 sel_ch_q, sel_ch_d;
   logic                 sel_sgl_q, sel_sgl_d;
   logic                 msbf_q, msbf_d;
   logic                 conv_start_q, conv_start_d;
   logic                 frame_done_q, frame_done_d;
   logic                 frame_abort_q, frame_abort_d;
   logic [DATA_BITS-1:0] result_q, result_d;
   logic [IDX_W-1:0]     idx_q, idx_d;

   // Conversion result. The channel and mode bits are already registered by the
   // time the MSBF bit arrives. In differential mode, one extra bit holds the
   // borrow, so a negative difference can be detected and clamped to zero.
   logic [DATA_BITS-1:0] in_pos, in_neg, result_calc;
   logic [DATA_BITS:0]   diff;

   always_comb begin
      in_pos = sel_ch_q ? ch1_sample : ch0_sample;
      in_neg = sel_ch_q ? ch0_sample : ch1_sample;
      diff   = {1'b0, in_pos} - {1'b0, in_neg};
      if (sel_sgl_q) begin
         result_calc = in_pos;
      end else if (diff[DATA_BITS]) begin
         result_calc = '0;
      end else begin
         result_calc = diff[DATA_BITS-1:0];
      end
   end

   // NOTE: every signal gets a default before the case statement. A path that
   // forgets an assignment then holds the flop value and does not infer a latch.
   always_comb begin
      state_d       = state_q;
      miso_d        = miso_q;
      miso_oe_d     = miso_oe_q;
      sel_ch_d      = sel_ch_q;
      sel_sgl_d     = sel_sgl_q;
      msbf_d        = msbf_q;
      result_d      = result_q;
      idx_d         = idx_q;
      conv_start_d  = 1'b0;
      frame_done_d  = 1'b0;
      frame_abort_d = 1'b0;

      if (cs_s) begin
         // A deselect overrides any sck event seen in the same clk.
         state_d       = ST_IDLE;
         miso_d        = 1'b0;
         miso_oe_d     = 1'b0;
         frame_abort_d = (state_q != ST_IDLE) && (state_q != ST_DONE);
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d   = ST_WAIT_START;
               miso_oe_d = 1'b1;
               miso_d    = 1'b0;
            end
            ST_WAIT_START: begin
               // Leading zeros before the start bit are ignored.
               if (sck_rise && mosi_s) state_d = ST_SGL;
            end
            ST_SGL: begin
               if (sck_rise) begin
                  sel_sgl_d = mosi_s;
                  state_d   = ST_ODD;
               end
            end
            ST_ODD: begin
               if (sck_rise) begin
                  sel_ch_d = mosi_s;
                  state_d  = ST_MSBF;
               end
            end
            ST_MSBF: begin
               if (sck_rise) begin
                  msbf_d       = mosi_s;
                  result_d     = result_calc;
                  conv_start_d = 1'b1;
                  state_d      = ST_NULL;
               end
            end
            ST_NULL: begin
               if (sck_fall) begin
                  miso_d  = 1'b0;
                  idx_d   = IDX_W'(DATA_BITS - 1);
                  state_d = ST_DATA;
               end
            end
            ST_DATA: begin
               if (sck_fall) begin
                  miso_d = result_q[idx_q];
                  if (idx_q == IDX_W'(0)) begin
                     if (msbf_q) begin
                        state_d      = ST_DONE;
                        frame_done_d = 1'b1;
                     end else begin
                        // Bit 0 has just been sent. The LSB-first tail
                        // restarts at bit 1.
                        idx_d   = IDX_W'(1);
                        state_d = ST_LSBF;
                     end
                  end else begin
                     idx_d = idx_q - IDX_W'(1);
                  end
               end
            end
            ST_LSBF: begin
               if (sck_fall) begin
                  miso_d = result_q[idx_q];
                  if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                     state_d      = ST_DONE;
                     frame_done_d = 1'b1;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
            ST_DONE: begin
               if (sck_fall) miso_d = 1'b0;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only. Every flop then
   // sees the pre-edge value of every other flop, whatever the statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sck_sync_q    <= '0;
         cs_sync_q     <= '1;
         mosi_sync_q   <= '0;
         sck_prev_q    <= 1'b0;
         state_q       <= ST_IDLE;
         miso_q        <= 1'b0;
         miso_oe_q     <= 1'b0;
         sel_ch_q      <= 1'b0;
         sel_sgl_q     <= 1'b0;
         msbf_q        <= 1'b0;
         conv_start_q  <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_abort_q <= 1'b0;
         result_q      <= '0;
         idx_q         <= '0;
      end else begin
         sck_sync_q    <= sck_sync_d;
         cs_sync_q     <= cs_sync_d;
         mosi_sync_q   <= mosi_sync_d;
         sck_prev_q    <= sck_prev_d;
         state_q       <= state_d;
         miso_q        <= miso_d;
         miso_oe_q     <= miso_oe_d;
         sel_ch_q      <= sel_ch_d;
         sel_sgl_q     <= sel_sgl_d;
         msbf_q        <= msbf_d;
         conv_start_q  <= conv_start_d;
         frame_done_q  <= frame_done_d;
         frame_abort_q <= frame_abort_d;
         result_q      <= result_d;
         idx_q         <= idx_d;
      end
   end

   assign miso        = miso_q;
   assign miso_oe     = miso_oe_q;
   assign sel_ch      = sel_ch_q;
   assign sel_sgl     = sel_sgl_q;
   assign conv_start  = conv_start_q;
   assign frame_done  = frame_done_q;
   assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// -----------------------------------------------------------------------------
// tb_adc_spi_responder
//
// Acts as a mode-0 SPI master for adc_spi_responder. Runs directed frames and
// then randomized frames. Each returned miso bit, each decoded selection bit and
// each pulse count is compared against a reference model. The model works from
// the ADC read rules with plain integer arithmetic and a queue of bits.
// -----------------------------------------------------------------------------
module tb_adc_spi_responder;

   localparam int DB       = 10;
   localparam int SS       = 2;
   localparam int SCK_HALF = 40;   // 80 ns sck period against a 10 ns clk

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          sck = 1'b0;
   logic          cs_n = 1'b1;
   logic          mosi = 1'b0;
   logic [DB-1:0] ch0_sample = '0;
   logic [DB-1:0] ch1_sample = '0;
   logic          miso, miso_oe, sel_ch, sel_sgl;
   logic          conv_start, frame_done, frame_abort;

   int n_checks = 0;
   int n_errors = 0;

   // Cumulative pulse counters. Each frame compares deltas taken against them.
   int conv_cnt  = 0;
   int done_cnt  = 0;
   int abort_cnt = 0;
   int done_fall = -1;
   int fall_cnt  = 0;

   adc_spi_responder #(.DATA_BITS(DB), .SYNC_STAGES(SS)) dut (
      .clk        (clk),
      .reset      (reset),
      .sck        (sck),
      .cs_n       (cs_n),
      .mosi       (mosi),
      .ch0_sample (ch0_sample),
      .ch1_sample (ch1_sample),
      .miso       (miso),
      .miso_oe    (miso_oe),
      .sel_ch     (sel_ch),
      .sel_sgl    (sel_sgl),
      .conv_start (conv_start),
      .frame_done (frame_done),
      .frame_abort(frame_abort)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (conv_start) conv_cnt++;
      if (frame_done) begin
         done_cnt++;
         done_fall = fall_cnt;
      end
      if (frame_abort) abort_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: value the ADC reports for a given command.
   function automatic logic [DB-1:0] model_result(input bit sgl, input bit odd,
                                                  input int c0, input int c1);
      int pos, neg, d;
      pos = odd ? c1 : c0;
      neg = odd ? c0 : c1;
      if (sgl) return DB'(pos);
      d = pos - neg;
      if (d < 0) d = 0;
      return DB'(d);
   endfunction

   // One sck period. mosi is set right after the previous fall, and miso is
   // sampled just before the rise, where a mode-0 master reads it.
   task automatic sck_cycle(input logic m, output logic s);
      mosi = m;
      #38;
      s = miso;
      #2;
      sck = 1'b1;
      #SCK_HALF;
      sck = 1'b0;
      fall_cnt++;
   endtask

   // A full frame: optional leading zeros, the command, then the tail.
   // abort_after >= 0 raises cs_n after that many data bits.
   // cs_held skips the cs_n falling edge because the master is already selected.
   task automatic run_frame(input string name, input int lz, input bit sgl, input bit odd,
                            input bit msbf, input logic [DB-1:0] c0, input logic [DB-1:0] c1,
                            input int abort_after, input bit cs_held);
      logic          s;
      bit            expq[$];
      logic [DB-1:0] r;
      int            cmd_len, conv_b, done_b, abort_b, nbits;
      logic          e;

      ch0_sample = c0;
      ch1_sample = c1;
      conv_b     = conv_cnt;
      done_b     = done_cnt;
      abort_b    = abort_cnt;
      fall_cnt   = 0;
      if (!cs_held) begin
         cs_n = 1'b0;
         #40;
      end
      for (int i = 0; i < lz; i++) sck_cycle(1'b0, s);
      sck_cycle(1'b1, s);
      sck_cycle(sgl, s);
      sck_cycle(odd, s);
      sck_cycle(msbf, s);
      cmd_len = lz + 4;

      // The samples have been latched by now. Changing them must not disturb
      // the frame in progress.
      ch0_sample = DB'($urandom_range(1023));
      ch1_sample = DB'($urandom_range(1023));

      r = model_result(sgl, odd, int'(c0), int'(c1));
      expq.push_back(1'b0);
      for (int b = DB - 1; b >= 0; b--) expq.push_back(r[b]);
      if (!msbf) for (int b = 1; b < DB; b++) expq.push_back(r[b]);

      nbits = (abort_after >= 0) ? abort_after + 1 : expq.size() + 1;
      for (int k = 0; k < nbits; k++) begin
         sck_cycle(1'b0, s);
         e = (k < expq.size()) ? expq[k] : 1'b0;
         check($sformatf("%s miso[%0d]", name, k), {31'b0, s}, {31'b0, e});
      end

      check({name, " sel_sgl"}, {31'b0, sel_sgl}, {31'b0, sgl});
      check({name, " sel_ch"}, {31'b0, sel_ch}, {31'b0, odd});
      check({name, " miso_oe"}, {31'b0, miso_oe}, 32'd1);
      check({name, " conv_start count"}, conv_cnt - conv_b, 32'd1);

      if (abort_after >= 0) begin
         cs_n = 1'b1;
         #30;
         check({name, " miso_oe after abort"}, {31'b0, miso_oe}, 32'd0);
         #20;
         check({name, " frame_abort count"}, abort_cnt - abort_b, 32'd1);
         check({name, " frame_done count"}, done_cnt - done_b, 32'd0);
      end else begin
         check({name, " frame_done count"}, done_cnt - done_b, 32'd1);
         check({name, " frame_done fall"}, done_fall, cmd_len + (msbf ? DB : 2 * DB - 1));
         cs_n = 1'b1;
         #60;
         check({name, " no frame_abort"}, abort_cnt - abort_b, 32'd0);
         check({name, " miso_oe released"}, {31'b0, miso_oe}, 32'd0);
      end
      #40;
   endtask

   initial begin
      logic s;
      int   abort_b;

      #3;
      check("reset outputs",
            {25'b0, miso, miso_oe, sel_ch, sel_sgl, conv_start, frame_done, frame_abort}, 32'd0);
      #20;
      reset = 1'b1;
      #40;

      run_frame("se_ch0", 0, 1'b1, 1'b0, 1'b1, 10'h2A5, 10'h155, -1, 1'b0);
      run_frame("se_ch1_lz", 2, 1'b1, 1'b1, 1'b1, 10'h000, 10'h3FF, -1, 1'b0);
      run_frame("lsbf_tail", 0, 1'b1, 1'b0, 1'b0, 10'h001, 10'h3C3, -1, 1'b0);
      run_frame("diff_clamp", 0, 1'b0, 1'b0, 1'b1, 10'h100, 10'h180, -1, 1'b0);
      run_frame("diff_pos", 0, 1'b0, 1'b1, 1'b1, 10'h100, 10'h180, -1, 1'b0);
      run_frame("abort", 1, 1'b1, 1'b1, 1'b1, 10'h2F0, 10'h1AB, 6, 1'b0);
      run_frame("after_abort", 0, 1'b1, 1'b0, 1'b0, 10'h0F5, 10'h311, -1, 1'b0);

      // Reset asserted in the middle of the data phase.
      abort_b    = abort_cnt;
      ch1_sample = 10'h3A5;
      cs_n       = 1'b0;
      #40;
      sck_cycle(1'b1, s);
      sck_cycle(1'b1, s);
      sck_cycle(1'b1, s);
      sck_cycle(1'b1, s);
      for (int i = 0; i < 4; i++) sck_cycle(1'b0, s);
      #10;
      reset = 1'b0;
      #1;
      check("mid-frame reset outputs",
            {25'b0, miso, miso_oe, sel_ch, sel_sgl, conv_start, frame_done, frame_abort}, 32'd0);
      #19;
      reset = 1'b1;
      #40;
      check("no abort on reset", abort_cnt - abort_b, 32'd0);
      run_frame("post_reset", 0, 1'b1, 1'b1, 1'b1, 10'h06C, 10'h2D2, -1, 1'b1);

      for (int n = 0; n < 20; n++) begin
         run_frame($sformatf("rand%0d", n), int'($urandom_range(2)),
                   1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                   DB'($urandom_range(1023)), DB'($urandom_range(1023)), -1, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
